rtc_core: RTL and testbench

//  Timekeeping core for the RTC block, running in the rtc_clk_i domain. It divides
//  rtc_clk_i by a programmable prescaler into a 1-second tick, and advances a 32-bit

---
 rtl/rtc_core.sv | 129 ++++++++++++
 tb/tb_rtc_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_core.sv
// RTC timekeeping core: programmable prescaler -> 1 s tick -> 32-bit seconds counter,
// alarm compare, overflow flag and write-lockout FSM. Option macro: RTC_ALRM_AUTOCLR_EN.
module rtc_core #(
  parameter int                    PSCR_WIDTH = 20,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [PSCR_WIDTH-1:0] PSCR_RST   = 'h7FFF
) (
  input  logic                  rtc_clk_i,
  input  logic                  rtc_rst_i,
  input  logic                  en_i,
  input  logic                  cmf_i,
  input  logic                  pscr_wr_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic                  cnt_wr_i,
  input  logic [CNT_WIDTH-1:0]  cnt_i,
  input  logic [CNT_WIDTH-1:0]  alrm_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  sec_o,
  output logic                  alrm_o,
  output logic                  ovf_o,
  output logic                  lwoff_o
);

  typedef enum logic {LW_IDLE = 1'b0, LW_BUSY = 1'b1} lw_state_e;

  localparam logic [PSCR_WIDTH-1:0] PSCR_MIN = PSCR_WIDTH'(2);

  lw_state_e             lw_state_q, lw_state_d;
  logic [1:0]            lw_cnt_q, lw_cnt_d;
  logic [PSCR_WIDTH-1:0] pscr_q, pscr_d;
  logic [PSCR_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sec_q, sec_d;
  logic                  alrm_q, alrm_d;
  logic                  ovf_q, ovf_d;

  logic                  run;
  logic                  tick;
  logic                  wr_ok;
  logic                  wrap;
  logic [PSCR_WIDTH-1:0] pscr_wr_val;
  logic [CNT_WIDTH-1:0]  cnt_tick_val;

  assign run         = en_i & ~cmf_i;
  assign tick        = run & (div_q == '0);
  assign wr_ok       = cmf_i & (lw_state_q == LW_IDLE);
  assign wrap        = (cnt_q == '1);
  assign pscr_wr_val = (pscr_i < PSCR_MIN) ? PSCR_MIN : pscr_i;

`ifdef RTC_ALRM_AUTOCLR_EN
  // Reload to 0 after the alarm second; at alrm_i=='1 this coincides with natural wrap.
  assign cnt_tick_val = (cnt_q == alrm_i) ? '0 : cnt_q + CNT_WIDTH'(1);
`else
  assign cnt_tick_val = cnt_q + CNT_WIDTH'(1);
`endif

  always_comb begin
    pscr_d = pscr_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    sec_d  = tick;
    alrm_d = tick & (cnt_tick_val == alrm_i);
    ovf_d  = tick & wrap;
    if (run) begin
      div_d = tick ? pscr_q : div_q - PSCR_WIDTH'(1);
    end
    if (tick) begin
      cnt_d = cnt_tick_val;
    end
    // Writes only land while cmf_i freezes counting, so they never race a tick.
    if (wr_ok && pscr_wr_i) begin
      pscr_d = pscr_wr_val;
      div_d  = pscr_wr_val;
    end
    if (wr_ok && cnt_wr_i) begin
      cnt_d = cnt_i;
    end
  end

  always_comb begin
    lw_state_d = lw_state_q;
    lw_cnt_d   = lw_cnt_q;
    case (lw_state_q)
      LW_IDLE: begin
        if (wr_ok && (pscr_wr_i || cnt_wr_i)) begin
          lw_state_d = LW_BUSY;
          lw_cnt_d   = 2'd2;
        end
      end
      LW_BUSY: begin
        if (lw_cnt_q == 2'd0) begin
          lw_state_d = LW_IDLE;
        end else begin
          lw_cnt_d = lw_cnt_q - 2'd1;
        end
      end
      default: lw_state_d = LW_IDLE;
    endcase
  end

  always_ff @(posedge rtc_clk_i or posedge rtc_rst_i) begin
    if (rtc_rst_i) begin
      lw_state_q <= LW_IDLE;
      lw_cnt_q   <= 2'd0;
      pscr_q     <= PSCR_RST;
      div_q      <= PSCR_RST;
      cnt_q      <= '0;
      sec_q      <= 1'b0;
      alrm_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      lw_state_q <= lw_state_d;
      lw_cnt_q   <= lw_cnt_d;
      pscr_q     <= pscr_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
      alrm_q     <= alrm_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign sec_o   = sec_q;
  assign alrm_o  = alrm_q;
  assign ovf_o   = ovf_q;
  assign lwoff_o = (lw_state_q == LW_IDLE);

endmodule

// File: tb/tb_rtc_core.sv
// Directed self-checking bench for rtc_core: prescaler timing, write lockout,
// wrap/overflow, alarm, run gating and asynchronous reset.
module tb_rtc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        cmf_i = 1'b0;
  logic        pscr_wr_i = 1'b0;
  logic [19:0] pscr_i = '0;
  logic        cnt_wr_i = 1'b0;
  logic [31:0] cnt_i = '0;
  logic [31:0] alrm_i = 32'h100;
  logic [31:0] cnt_o;
  logic        sec_o;
  logic        alrm_o;
  logic        ovf_o;
  logic        lwoff_o;

  int n_cmp = 0;
  int n_err = 0;

  rtc_core dut (
    .rtc_clk_i (clk),
    .rtc_rst_i (rst),
    .en_i      (en_i),
    .cmf_i     (cmf_i),
    .pscr_wr_i (pscr_wr_i),
    .pscr_i    (pscr_i),
    .cnt_wr_i  (cnt_wr_i),
    .cnt_i     (cnt_i),
    .alrm_i    (alrm_i),
    .cnt_o     (cnt_o),
    .sec_o     (sec_o),
    .alrm_o    (alrm_o),
    .ovf_o     (ovf_o),
    .lwoff_o   (lwoff_o)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cycles from now until sec_o is seen; returns limit+1 on timeout
  task automatic wait_sec(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sec_o && n <= limit);
  endtask

  task automatic drive_wr(input logic do_pscr, input logic [19:0] p,
                          input logic do_cnt, input logic [31:0] c);
    pscr_i    = p;
    cnt_i     = c;
    pscr_wr_i = do_pscr;
    cnt_wr_i  = do_cnt;
    step();
    pscr_wr_i = 1'b0;
    cnt_wr_i  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_cmp++; if (cnt_o !== 32'h0) begin n_err++; $display("FAIL rst_cnt got %h want 0", cnt_o); end
    n_cmp++; if (lwoff_o !== 1'b1) begin n_err++; $display("FAIL rst_lwoff got %b want 1", lwoff_o); end
    n_cmp++; if ({sec_o, alrm_o, ovf_o} !== 3'b000) begin n_err++; $display("FAIL rst_pulses got %b want 000", {sec_o, alrm_o, ovf_o}); end
    en_i = 1'b1;
    wait_sec(32'h9000, n);
    n_cmp++; if (n !== 32'h8000) begin n_err++; $display("FAIL first_tick got %0d want %0d", n, 32'h8000); end
    n_cmp++; if (cnt_o !== 32'd1) begin n_err++; $display("FAIL first_cnt got %h want 1", cnt_o); end
    wait_sec(32'h9000, n);
    n_cmp++; if (n !== 32'h8000) begin n_err++; $display("FAIL second_tick got %0d want %0d", n, 32'h8000); end
    n_cmp++; if (cnt_o !== 32'd2) begin n_err++; $display("FAIL second_cnt got %h want 2", cnt_o); end
  endtask

  task automatic test_prescaler();
    int n;
    cmf_i = 1'b1;
    drive_wr(1'b1, 20'd4, 1'b0, 32'h0);
    n_cmp++; if (lwoff_o !== 1'b0) begin n_err++; $display("FAIL lw_c1 got %b want 0", lwoff_o); end
    drive_wr(1'b1, 20'd9, 1'b0, 32'h0);
    n_cmp++; if (lwoff_o !== 1'b0) begin n_err++; $display("FAIL lw_c2 got %b want 0", lwoff_o); end
    step();
    n_cmp++; if (lwoff_o !== 1'b0) begin n_err++; $display("FAIL lw_c3 got %b want 0", lwoff_o); end
    step();
    n_cmp++; if (lwoff_o !== 1'b1) begin n_err++; $display("FAIL lw_c4 got %b want 1", lwoff_o); end
    cmf_i = 1'b0;
    wait_sec(20, n);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL pscr4_p1 got %0d want 5", n); end
    n_cmp++; if (cnt_o !== 32'd3) begin n_err++; $display("FAIL pscr4_cnt1 got %h want 3", cnt_o); end
    wait_sec(20, n);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL pscr4_p2 got %0d want 5", n); end
    n_cmp++; if (cnt_o !== 32'd4) begin n_err++; $display("FAIL pscr4_cnt2 got %h want 4", cnt_o); end
    // pscr=1 clamps to 2; cmf_i drops right after the write and the lockout still runs
    cmf_i = 1'b1;
    drive_wr(1'b1, 20'd1, 1'b0, 32'h0);
    cmf_i = 1'b0;
    en_i  = 1'b0;
    n_cmp++; if (lwoff_o !== 1'b0) begin n_err++; $display("FAIL lwdrop_c1 got %b want 0", lwoff_o); end
    step();
    n_cmp++; if (lwoff_o !== 1'b0) begin n_err++; $display("FAIL lwdrop_c2 got %b want 0", lwoff_o); end
    step();
    n_cmp++; if (lwoff_o !== 1'b0) begin n_err++; $display("FAIL lwdrop_c3 got %b want 0", lwoff_o); end
    step();
    n_cmp++; if (lwoff_o !== 1'b1) begin n_err++; $display("FAIL lwdrop_c4 got %b want 1", lwoff_o); end
    en_i = 1'b1;
    wait_sec(20, n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL pscr1_p1 got %0d want 3", n); end
    n_cmp++; if (cnt_o !== 32'd5) begin n_err++; $display("FAIL pscr1_cnt1 got %h want 5", cnt_o); end
    wait_sec(20, n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL pscr1_p2 got %0d want 3", n); end
    n_cmp++; if (cnt_o !== 32'd6) begin n_err++; $display("FAIL pscr1_cnt2 got %h want 6", cnt_o); end
    cmf_i = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    drive_wr(1'b1, 20'd2, 1'b1, 32'hFFFF_FFFE);
    repeat (3) step();
    cmf_i = 1'b0;
    wait_sec(20, n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL wrap_p1 got %0d want 3", n); end
    n_cmp++; if ({cnt_o, ovf_o} !== {32'hFFFF_FFFF, 1'b0}) begin n_err++; $display("FAIL wrap_pre got cnt=%h ovf=%b want ffffffff/0", cnt_o, ovf_o); end
    wait_sec(20, n);
    n_cmp++; if ({cnt_o, ovf_o, sec_o} !== {32'h0, 1'b1, 1'b1}) begin n_err++; $display("FAIL wrap_ovf got cnt=%h ovf=%b sec=%b want 0/1/1", cnt_o, ovf_o, sec_o); end
    cmf_i = 1'b1;
    step();
    n_cmp++; if ({sec_o, ovf_o} !== 2'b00) begin n_err++; $display("FAIL wrap_after got %b want 00", {sec_o, ovf_o}); end
  endtask

  task automatic test_alarm();
    int n;
    alrm_i = 32'd5;
    drive_wr(1'b0, 20'd0, 1'b1, 32'd5);
    repeat (3) begin
      n_cmp++; if (alrm_o !== 1'b0) begin n_err++; $display("FAIL alrm_on_write got %b want 0", alrm_o); end
      step();
    end
    drive_wr(1'b0, 20'd0, 1'b1, 32'd3);
    repeat (3) step();
    cmf_i = 1'b0;
    wait_sec(20, n);
    n_cmp++; if ({cnt_o, alrm_o} !== {32'd4, 1'b0}) begin n_err++; $display("FAIL alrm_t1 got cnt=%h alrm=%b want 4/0", cnt_o, alrm_o); end
    wait_sec(20, n);
    n_cmp++; if ({cnt_o, alrm_o, sec_o} !== {32'd5, 1'b1, 1'b1}) begin n_err++; $display("FAIL alrm_t2 got cnt=%h alrm=%b sec=%b want 5/1/1", cnt_o, alrm_o, sec_o); end
    wait_sec(20, n);
`ifdef RTC_ALRM_AUTOCLR_EN
    n_cmp++; if ({cnt_o, alrm_o, ovf_o} !== {32'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL alrm_t3 got cnt=%h alrm=%b ovf=%b want 0/0/0", cnt_o, alrm_o, ovf_o); end
`else
    n_cmp++; if ({cnt_o, alrm_o, ovf_o} !== {32'd6, 1'b0, 1'b0}) begin n_err++; $display("FAIL alrm_t3 got cnt=%h alrm=%b ovf=%b want 6/0/0", cnt_o, alrm_o, ovf_o); end
`endif
    cmf_i = 1'b1;
  endtask

  task automatic test_gating();
    int n;
    logic [31:0] c5;
`ifdef RTC_ALRM_AUTOCLR_EN
    c5 = 32'd0;
`else
    c5 = 32'd6;
`endif
    cmf_i = 1'b0;
    en_i  = 1'b0;
    drive_wr(1'b0, 20'd0, 1'b1, 32'h1234);
    n_cmp++; if ({cnt_o, lwoff_o} !== {c5, 1'b1}) begin n_err++; $display("FAIL wr_no_cmf got cnt=%h lwoff=%b want %h/1", cnt_o, lwoff_o, c5); end
    cmf_i = 1'b1;
    drive_wr(1'b1, 20'd4, 1'b0, 32'h0);
    repeat (3) step();
    cmf_i = 1'b0;
    en_i  = 1'b1;
    step();
    step();
    en_i = 1'b0;
    repeat (3) begin
      step();
      n_cmp++; if (sec_o !== 1'b0) begin n_err++; $display("FAIL hold_sec got %b want 0", sec_o); end
    end
    en_i = 1'b1;
    wait_sec(20, n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL resume_p got %0d want 3", n); end
    n_cmp++; if (cnt_o !== c5 + 32'd1) begin n_err++; $display("FAIL resume_cnt got %h want %h", cnt_o, c5 + 32'd1); end
  endtask

  task automatic test_async_reset();
    step();
    step();
    cmf_i = 1'b1;
    drive_wr(1'b0, 20'd0, 1'b1, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({cnt_o, lwoff_o} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL arst_state got cnt=%h lwoff=%b want 0/1", cnt_o, lwoff_o); end
    n_cmp++; if ({sec_o, alrm_o, ovf_o} !== 3'b000) begin n_err++; $display("FAIL arst_pulses got %b want 000", {sec_o, alrm_o, ovf_o}); end
    step();
    rst   = 1'b0;
    cmf_i = 1'b0;
    en_i  = 1'b1;
    repeat (10) begin
      step();
      n_cmp++; if (sec_o !== 1'b0) begin n_err++; $display("FAIL arst_pscr got sec=%b want 0", sec_o); end
    end
    n_cmp++; if ({cnt_o, lwoff_o} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL arst_after got cnt=%h lwoff=%b want 0/1", cnt_o, lwoff_o); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_wrap();
    test_alarm();
    test_gating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
